// File: rtl/vga_ball_locator.sv
// vga_ball_locator
//   Watches a VGA pixel stream (negative-logic hsync/vsync, 4-bit RGB, one pixel
//   per clk). It rebuilds pixel coordinates from the sync pulses, tests each
//   active pixel against a "red ball" colour window, and once per frame reports
//   the centre of the bounding box of all matching pixels.
//
// Ports
//   clk          in   1   pixel clock, one pixel per cycle
//   reset        in   1   synchronous, active-low reset
//   hsync        in   1   horizontal sync, low = pulse
//   vsync        in   1   vertical sync, low = pulse
//   red          in   4   pixel red
//   green        in   4   pixel green
//   blue         in   4   pixel blue
//   ball_x       out  10  centre x of last found object
//   ball_y       out  10  centre y of last found object
//   ball_found   out  1   last completed frame had enough matching pixels
//   frame_valid  out  1   one-cycle strobe when the results update
//   locked       out  1   sync timing is being tracked
module vga_ball_locator #(
  parameter int         H_BP      = 48,
  parameter int         H_ACTIVE  = 640,
  parameter int         V_BP      = 33,
  parameter int         V_ACTIVE  = 480,
  parameter int         H_TIMEOUT = 1023,
  parameter logic [3:0] R_MIN     = 4'd12,
  parameter logic [3:0] G_MAX     = 4'd4,
  parameter logic [3:0] B_MAX     = 4'd4,
  parameter int         MIN_PIX   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_found,
  output logic       frame_valid,
  output logic       locked
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    TRACK     = 2'd1,
    REPORT    = 2'd2
  } state_t;

  localparam logic [10:0] H_START   = 11'(H_BP);
  localparam logic [10:0] H_END     = 11'(H_BP + H_ACTIVE);
  localparam logic [10:0] V_START   = 11'(V_BP);
  localparam logic [10:0] V_END     = 11'(V_BP + V_ACTIVE);
  localparam logic [9:0]  H_OFS     = 10'(H_BP);
  localparam logic [9:0]  V_OFS     = 10'(V_BP);
  localparam logic [9:0]  H_LIMIT   = 10'(H_TIMEOUT);
  localparam logic [18:0] MIN_COUNT = 19'(MIN_PIX);

  logic        hs1, hs2, vs1, vs2;
  logic [3:0]  red1, green1, blue1;
  logic        h_rise, v_rise, v_fall;
  logic [9:0]  hcount, vcount;
  logic        h_act, v_act, match;
  logic [9:0]  pix_x, pix_y;
  state_t      state, state_next;
  logic        clear_acc, accumulate, do_report;
  logic [9:0]  xmin, xmax, ymin, ymax;
  logic [18:0] mcount;
  logic [10:0] sum_x, sum_y;
  logic        found;

  // Input register stage plus one extra sync stage for edge detection.
  // The sync stages reset to the idle (high) level so that leaving reset in
  // the middle of a frame never looks like a sync rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs1    <= 1'b1;
      hs2    <= 1'b1;
      vs1    <= 1'b1;
      vs2    <= 1'b1;
      red1   <= '0;
      green1 <= '0;
      blue1  <= '0;
    end else begin
      hs1    <= hsync;
      hs2    <= hs1;
      vs1    <= vsync;
      vs2    <= vs1;
      red1   <= red;
      green1 <= green;
      blue1  <= blue;
    end
  end

  assign h_rise = hs1 & ~hs2;
  assign v_rise = vs1 & ~vs2;
  assign v_fall = ~vs1 & vs2;

  // Pixel and line counters. hcount saturates so a missing hsync is visible
  // as a stuck value that the FSM treats as loss of lock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      if (h_rise)
        hcount <= '0;
      else if (hcount != H_LIMIT)
        hcount <= hcount + 10'd1;
      if (v_rise)
        vcount <= '0;
      else if (h_rise)
        vcount <= vcount + 10'd1;
    end
  end

  // Active-window decode and colour window test on the registered pixel.
  always_comb begin
    h_act = ({1'b0, hcount} >= H_START) && ({1'b0, hcount} < H_END);
    v_act = ({1'b0, vcount} >= V_START) && ({1'b0, vcount} < V_END);
    pix_x = hcount - H_OFS;
    pix_y = vcount - V_OFS;
    match = h_act && v_act && (red1 >= R_MIN) && (green1 <= G_MAX) && (blue1 <= B_MAX);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset)
      state <= WAIT_SYNC;
    else
      state <= state_next;
  end

  // Next-state logic. A stalled hcount wins over a frame end so a broken
  // stream never produces a report.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SYNC: if (v_rise) state_next = TRACK;
      TRACK: begin
        if (hcount == H_LIMIT)
          state_next = WAIT_SYNC;
        else if (v_fall)
          state_next = REPORT;
      end
      REPORT:    state_next = TRACK;
      default:   state_next = WAIT_SYNC;
    endcase
  end

  // State outputs. A vsync rise in TRACK restarts the accumulation, which
  // covers a glitch that skipped the frame-end report.
  always_comb begin
    locked     = 1'b0;
    clear_acc  = 1'b0;
    accumulate = 1'b0;
    do_report  = 1'b0;
    case (state)
      WAIT_SYNC: clear_acc = v_rise;
      TRACK: begin
        locked     = 1'b1;
        clear_acc  = v_rise;
        accumulate = match && !v_rise;
      end
      REPORT: begin
        locked    = 1'b1;
        clear_acc = 1'b1;
        do_report = 1'b1;
      end
      default: ;
    endcase
  end

  // Bounding box and match counter. An empty box (mcount == 0) is loaded
  // directly by the first match instead of being compared against.
  always_ff @(posedge clk) begin
    if (!reset || clear_acc) begin
      xmin   <= '0;
      xmax   <= '0;
      ymin   <= '0;
      ymax   <= '0;
      mcount <= '0;
    end else if (accumulate) begin
      if (mcount == '0) begin
        xmin <= pix_x;
        xmax <= pix_x;
        ymin <= pix_y;
        ymax <= pix_y;
      end else begin
        if (pix_x < xmin) xmin <= pix_x;
        if (pix_x > xmax) xmax <= pix_x;
        if (pix_y < ymin) ymin <= pix_y;
        if (pix_y > ymax) ymax <= pix_y;
      end
      if (mcount != '1)
        mcount <= mcount + 19'd1;
    end
  end

  assign sum_x = {1'b0, xmin} + {1'b0, xmax};
  assign sum_y = {1'b0, ymin} + {1'b0, ymax};
  assign found = (mcount >= MIN_COUNT);

  // Result registers, updated from the one-cycle REPORT state. When too few
  // pixels matched, the previous centre is kept and only ball_found drops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ball_x      <= '0;
      ball_y      <= '0;
      ball_found  <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= do_report;
      if (do_report) begin
        ball_found <= found;
        if (found) begin
          ball_x <= 10'(sum_x >> 1);
          ball_y <= 10'(sum_y >> 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_ball_locator.sv
// tb_vga_ball_locator
//   Drives a scaled-down VGA stream (small porches and active area so that many
//   frames fit in a short run) into vga_ball_locator. Each frame is painted on a
//   canvas covering every cycle of the frame; a reference model finds the ball
//   directly from that canvas in screen coordinates.
module tb_vga_ball_locator;

  localparam int HBP  = 4;
  localparam int HA   = 16;
  localparam int HFP  = 3;
  localparam int HSW  = 4;
  localparam int LH   = 1 + HBP + HA + HFP;
  localparam int LT   = LH + HSW;
  localparam int VSW  = 2;
  localparam int VBP  = 2;
  localparam int VA   = 10;
  localparam int VFP  = 2;
  localparam int NL   = VSW + VBP + VA + VFP;
  localparam int HTO  = 63;
  localparam int MINP = 4;
  localparam int RMIN = 12;
  localparam int GMAX = 4;
  localparam int BMAX = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [3:0] red   = '0;
  logic [3:0] green = '0;
  logic [3:0] blue  = '0;
  logic [9:0] ball_x, ball_y;
  logic       ball_found, frame_valid, locked;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] cr [NL][LT];
  logic [3:0] cg [NL][LT];
  logic [3:0] cb [NL][LT];

  bit         tracking;
  bit         frame_ok;
  bit         res_found;
  logic [9:0] res_x, res_y;
  bit         held_found;
  logic [9:0] held_x, held_y;

  vga_ball_locator #(
    .H_BP(HBP), .H_ACTIVE(HA), .V_BP(VBP), .V_ACTIVE(VA),
    .H_TIMEOUT(HTO), .MIN_PIX(MINP)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .ball_x(ball_x), .ball_y(ball_y), .ball_found(ball_found),
    .frame_valid(frame_valid), .locked(locked)
  );

  always #20 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one pixel cycle; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic hs, input logic vs,
                               input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    hsync = hs;
    vsync = vs;
    red   = r;
    green = g;
    blue  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_canvas();
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < LT; c++) begin
        cr[l][c] = '0;
        cg[l][c] = '0;
        cb[l][c] = '0;
      end
  endtask

  task automatic random_canvas();
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < LT; c++) begin
        cr[l][c] = 4'($urandom_range(15, 0));
        cg[l][c] = 4'($urandom_range(15, 0));
        cb[l][c] = 4'($urandom_range(15, 0));
      end
  endtask

  // Screen coordinates: the first cycle with hsync high is column -1-HBP and
  // the line where vsync returns high is row -VBP.
  task automatic put_pixel(input int x, input int y, input int r, input int g, input int b);
    int l, c;
    l = y + VSW + VBP;
    c = x + 1 + HBP;
    if (l >= 0 && l < NL && c >= 0 && c < LT) begin
      cr[l][c] = 4'(r);
      cg[l][c] = 4'(g);
      cb[l][c] = 4'(b);
    end
  endtask

  task automatic put_square(input int x0, input int y0, input int w, input int h);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        put_pixel(x, y, 15, 0, 0);
  endtask

  task automatic model_frame();
    int n, xmn, xmx, ymn, ymx, x, y;
    n = 0; xmn = 100000; xmx = -1; ymn = 100000; ymx = -1;
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < LT; c++) begin
        x = c - 1 - HBP;
        y = l - VSW - VBP;
        if (x >= 0 && x < HA && y >= 0 && y < VA &&
            int'(cr[l][c]) >= RMIN && int'(cg[l][c]) <= GMAX && int'(cb[l][c]) <= BMAX) begin
          n++;
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (y < ymn) ymn = y;
          if (y > ymx) ymx = y;
        end
      end
    res_found = (n >= MINP);
    res_x = 10'((xmn + xmx) / 2);
    res_y = 10'((ymn + ymx) / 2);
  endtask

  task automatic run_frame(input int stop_line);
    bit   pending, exp_lock;
    int   t;
    logic hs, vs;
    pending  = frame_ok;
    exp_lock = tracking;
    for (int l = 0; l < stop_line; l++)
      for (int c = 0; c < LT; c++) begin
        t  = l * LT + c;
        hs = (c < LH);
        vs = (l >= VSW);
        applyStimulus(hs, vs, cr[l][c], cg[l][c], cb[l][c]);
        if (t == VSW * LT + 1) begin
          tracking = 1'b1;
          exp_lock = 1'b1;
        end
        if (pending && t == 2) begin
          held_found = res_found;
          if (res_found) begin
            held_x = res_x;
            held_y = res_y;
          end
          checkOutput("report_x", ball_x, held_x);
          checkOutput("report_y", ball_y, held_y);
          checkOutput("report_found", {9'b0, ball_found}, {9'b0, held_found});
        end
        checkOutput("frame_valid", {9'b0, frame_valid}, {9'b0, (pending && t == 2)});
        checkOutput("locked", {9'b0, locked}, {9'b0, exp_lock});
        if (c == LT - 1) begin
          checkOutput("hold_x", ball_x, held_x);
          checkOutput("hold_y", ball_y, held_y);
          checkOutput("hold_found", {9'b0, ball_found}, {9'b0, held_found});
        end
      end
    frame_ok = 1'b0;
  endtask

  task automatic do_frame();
    run_frame(NL);
    model_frame();
    frame_ok = tracking;
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_x"}, ball_x, 10'd0);
    checkOutput({tag, "_y"}, ball_y, 10'd0);
    checkOutput({tag, "_found"}, {9'b0, ball_found}, 10'd0);
    checkOutput({tag, "_fv"}, {9'b0, frame_valid}, 10'd0);
    checkOutput({tag, "_locked"}, {9'b0, locked}, 10'd0);
  endtask

  initial begin
    tracking   = 1'b0;
    frame_ok   = 1'b0;
    held_found = 1'b0;
    held_x     = '0;
    held_y     = '0;
    res_found  = 1'b0;
    res_x      = '0;
    res_y      = '0;

    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
    check_reset_state("reset");
    reset = 1'b1;

    $display("[TB] black frames");
    clear_canvas();
    do_frame();
    do_frame();

    $display("[TB] red square");
    clear_canvas();
    put_square(5, 3, 5, 5);
    do_frame();

    $display("[TB] corner block on colour thresholds");
    clear_canvas();
    put_pixel(14, 8, 12, 4, 4);
    put_pixel(15, 8, 12, 4, 4);
    put_pixel(14, 9, 12, 4, 4);
    put_pixel(15, 9, 12, 4, 4);
    put_pixel(13, 9, 11, 0, 0);
    put_pixel(12, 9, 15, 5, 0);
    put_pixel(11, 9, 15, 0, 5);
    do_frame();

    $display("[TB] too few pixels, extra pixels in blanking");
    clear_canvas();
    put_pixel(0, 0, 15, 0, 0);
    put_pixel(3, 2, 15, 0, 0);
    put_pixel(6, 4, 15, 0, 0);
    put_pixel(-1, 5, 15, 0, 0);
    put_pixel(HA, 5, 15, 0, 0);
    put_pixel(2, -1, 15, 0, 0);
    put_pixel(2, VA, 15, 0, 0);
    do_frame();

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      random_canvas();
      do_frame();
    end

    $display("[TB] hsync stall");
    clear_canvas();
    put_square(2, 1, 6, 6);
    run_frame(8);
    for (int s = 0; s < 120; s++) begin
      applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
      checkOutput("stall_fv", {9'b0, frame_valid}, 10'd0);
      if (s == 20) checkOutput("stall_still_locked", {9'b0, locked}, 10'd1);
      if (s == 119) checkOutput("stall_lock_lost", {9'b0, locked}, 10'd0);
    end
    tracking = 1'b0;
    frame_ok = 1'b0;
    clear_canvas();
    put_square(8, 2, 3, 4);
    do_frame();
    clear_canvas();
    do_frame();

    $display("[TB] reset mid-frame");
    clear_canvas();
    put_square(5, 3, 5, 5);
    run_frame(8);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
    check_reset_state("midreset");
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
    reset = 1'b1;
    tracking   = 1'b0;
    frame_ok   = 1'b0;
    held_found = 1'b0;
    held_x     = '0;
    held_y     = '0;
    do_frame();
    clear_canvas();
    do_frame();
    do_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
